lcd_line_scheduler: RTL and testbench

Sequences the ping-pong line buffers between the SPI line ingester and the HDP pixel output. Tracks which buffer the writer fills and which buffer the reader drains. Generates the HDP line/frame timing: per line, WORDS_PER_LINE valid packets then BLANK_PER_LINE blanks; LINES_PER_FRAME lines; then BACK_PORCH cycles. Stalls cleanly on underrun and drops on overrun, so the top-level FSM no longer carries that logic. Instantiated under the top level, enabled while the top-level FSM is in NORMAL.

---
 rtl/lcd_line_scheduler_if.sv | 35 +++
 rtl/lcd_line_scheduler.sv | 172 +++++++++++++++++
 tb/tb_lcd_line_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_line_scheduler_if.sv
// Bundle between the line scheduler and its surroundings: writer-side
// handshake from the SPI ingester plus the HDP read/timing outputs.
interface lcd_line_scheduler_if #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
);
    // i_wrLineDone is a one-cycle pulse with no ready: the scheduler always
    // takes it, and a line arriving while both buffers are full is dropped.
    // o_valid qualifies o_rdAddr every cycle; the HDP side has no backpressure.
    logic              i_enable;
    logic              i_wrLineDone;
    logic              o_wrBuffer;
    logic              o_wrBlocked;
    logic              o_rdBuffer;
    logic [ADDR_W-1:0] o_rdAddr;
    logic              o_valid;
    logic              o_update;
    logic              o_lineStart;
    logic              o_frameStart;
    logic [CNT_W-1:0]  o_underrunCount;
    logic [CNT_W-1:0]  o_overrunCount;
    logic [2:0]        o_state;

    modport master (
        output i_enable, i_wrLineDone,
        input  o_wrBuffer, o_wrBlocked, o_rdBuffer, o_rdAddr, o_valid, o_update,
               o_lineStart, o_frameStart, o_underrunCount, o_overrunCount, o_state
    );

    modport slave (
        input  i_enable, i_wrLineDone,
        output o_wrBuffer, o_wrBlocked, o_rdBuffer, o_rdAddr, o_valid, o_update,
               o_lineStart, o_frameStart, o_underrunCount, o_overrunCount, o_state
    );
endinterface

// File: rtl/lcd_line_scheduler.sv
// Ping-pong line buffer sequencer: tracks writer/reader buffers and generates
// HDP line/frame timing with underrun stall and overrun drop.
module lcd_line_scheduler #(
    parameter int WORDS_PER_LINE  = 40,
    parameter int BLANK_PER_LINE  = 4,
    parameter int LINES_PER_FRAME = 1280,
    parameter int BACK_PORCH      = 24,
    parameter int UPDATE_CYCLES   = 28,
    parameter int CNT_W           = 16
) (
    input logic                 i_clock,
    input logic                 i_nReset,
    lcd_line_scheduler_if.slave bus
);
    localparam int ADDR_W  = $clog2(WORDS_PER_LINE);
    localparam int BLANK_W = $clog2(BLANK_PER_LINE + 1);
    localparam int LINE_W  = $clog2(LINES_PER_FRAME + 1);
    localparam int PORCH_W = $clog2(BACK_PORCH + 1);
    localparam int UPD_W   = $clog2(UPDATE_CYCLES + 1);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(BLANK_PER_LINE - 1);
    localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [PORCH_W-1:0] LAST_PORCH = PORCH_W'(BACK_PORCH - 1);
    localparam logic [UPD_W-1:0]   UPD_LIMIT  = UPD_W'(UPDATE_CYCLES);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_LINE = 3'd1;
    localparam logic [2:0] ACTIVE    = 3'd2;
    localparam logic [2:0] BLANK     = 3'd3;
    localparam logic [2:0] PORCH     = 3'd4;

    logic [2:0]         state, stateNext;
    logic [1:0]         full, fullNext;
    logic               wrBuffer, wrBufferNext;
    logic               rdBuffer, rdBufferNext;
    logic [ADDR_W-1:0]  rdAddr, rdAddrNext;
    logic [BLANK_W-1:0] blankCnt, blankCntNext;
    logic [LINE_W-1:0]  lineCnt, lineCntNext;
    logic [PORCH_W-1:0] porchCnt, porchCntNext;
    logic [UPD_W-1:0]   framePkt, framePktNext;
    logic [CNT_W-1:0]   underrunCount, underrunNext;
    logic [CNT_W-1:0]   overrunCount, overrunNext;
    logic               wrBlocked, valid, update, lineStart, frameStart;

    always_comb begin
        stateNext    = state;
        fullNext     = full;
        wrBufferNext = wrBuffer;
        rdBufferNext = rdBuffer;
        blankCntNext = blankCnt;
        lineCntNext  = lineCnt;
        porchCntNext = porchCnt;
        framePktNext = framePkt;
        underrunNext = underrunCount;
        overrunNext  = overrunCount;
        if (!bus.i_enable) begin
            stateNext    = IDLE;
            fullNext     = '0;
            wrBufferNext = 1'b0;
            rdBufferNext = 1'b0;
            blankCntNext = '0;
            lineCntNext  = '0;
            porchCntNext = '0;
            framePktNext = '0;
        end else begin
            if ((state == ACTIVE || state == BLANK) && framePkt != UPD_LIMIT)
                framePktNext = framePkt + UPD_W'(1);
            case (state)
                IDLE:      stateNext = WAIT_LINE;
                WAIT_LINE: if (full[rdBuffer]) stateNext = ACTIVE;
                ACTIVE:    if (rdAddr == LAST_ADDR) stateNext = BLANK;
                BLANK: begin
                    if (blankCnt == LAST_BLANK) begin
                        blankCntNext       = '0;
                        fullNext[rdBuffer] = 1'b0;
                        rdBufferNext       = ~rdBuffer;
                        if (lineCnt == LAST_LINE) begin
                            lineCntNext  = '0;
                            porchCntNext = '0;
                            stateNext    = PORCH;
                        end else begin
                            lineCntNext = lineCnt + LINE_W'(1);
                            // Readiness of the next line is judged on the
                            // flags as they stood before this cycle's write.
                            if (full[~rdBuffer]) begin
                                stateNext = ACTIVE;
                            end else begin
                                stateNext = WAIT_LINE;
                                if (underrunCount != '1)
                                    underrunNext = underrunCount + CNT_W'(1);
                            end
                        end
                    end else begin
                        blankCntNext = blankCnt + BLANK_W'(1);
                    end
                end
                PORCH: begin
                    if (porchCnt == LAST_PORCH) begin
                        stateNext    = WAIT_LINE;
                        framePktNext = '0;
                    end else begin
                        porchCntNext = porchCnt + PORCH_W'(1);
                    end
                end
                default: stateNext = IDLE;
            endcase
            // Write side sees pre-release flags, so a blocked write is dropped
            // even when the reader frees a buffer in the same cycle.
            if (bus.i_wrLineDone) begin
                if (full[wrBuffer]) begin
                    if (overrunCount != '1)
                        overrunNext = overrunCount + CNT_W'(1);
                end else begin
                    fullNext[wrBuffer] = 1'b1;
                    wrBufferNext       = ~wrBuffer;
                end
            end
        end
        rdAddrNext = (state == ACTIVE && stateNext == ACTIVE) ? rdAddr + ADDR_W'(1) : '0;
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state         <= IDLE;
            full          <= '0;
            wrBuffer      <= 1'b0;
            rdBuffer      <= 1'b0;
            rdAddr        <= '0;
            blankCnt      <= '0;
            lineCnt       <= '0;
            porchCnt      <= '0;
            framePkt      <= '0;
            underrunCount <= '0;
            overrunCount  <= '0;
            wrBlocked     <= 1'b0;
            valid         <= 1'b0;
            update        <= 1'b0;
            lineStart     <= 1'b0;
            frameStart    <= 1'b0;
        end else begin
            state         <= stateNext;
            full          <= fullNext;
            wrBuffer      <= wrBufferNext;
            rdBuffer      <= rdBufferNext;
            rdAddr        <= rdAddrNext;
            blankCnt      <= blankCntNext;
            lineCnt       <= lineCntNext;
            porchCnt      <= porchCntNext;
            framePkt      <= framePktNext;
            underrunCount <= underrunNext;
            overrunCount  <= overrunNext;
            wrBlocked     <= &fullNext;
            valid         <= (stateNext == ACTIVE);
            update        <= (stateNext == ACTIVE || stateNext == BLANK) && (framePktNext < UPD_LIMIT);
            lineStart     <= (stateNext == ACTIVE) && (state != ACTIVE);
            frameStart    <= (stateNext == ACTIVE) && (state != ACTIVE) && (lineCntNext == '0);
        end
    end

    assign bus.o_wrBuffer      = wrBuffer;
    assign bus.o_wrBlocked     = wrBlocked;
    assign bus.o_rdBuffer      = rdBuffer;
    assign bus.o_rdAddr        = rdAddr;
    assign bus.o_valid         = valid;
    assign bus.o_update        = update;
    assign bus.o_lineStart     = lineStart;
    assign bus.o_frameStart    = frameStart;
    assign bus.o_underrunCount = underrunCount;
    assign bus.o_overrunCount  = overrunCount;
    assign bus.o_state         = state;
endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Self-checking bench for lcd_line_scheduler: a buffer-queue reference model
// predicts every output cycle by cycle under directed and random stimulus.
module tb_lcd_line_scheduler;
    localparam int W  = 40;
    localparam int B  = 4;
    localparam int L  = 6;
    localparam int P  = 24;
    localparam int U  = 28;
    localparam int CW = 4;
    localparam int AW = $clog2(W);
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int EXP_W = 7 + AW + 2 * CW;

    logic clock;
    logic nReset;

    lcd_line_scheduler_if #(.ADDR_W(AW), .CNT_W(CW)) bus();

    lcd_line_scheduler #(
        .WORDS_PER_LINE(W), .BLANK_PER_LINE(B), .LINES_PER_FRAME(L),
        .BACK_PORCH(P), .UPDATE_CYCLES(U), .CNT_W(CW)
    ) dut (
        .i_clock (clock),
        .i_nReset(nReset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNum   = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model: filled lines form a FIFO of depth two; the reader
    // walks a line as positions 0..W+B-1, then porch, counted in plain ints.
    int mQ[$];
    int mWr, mRd, mPos, mLine, mPorch, mFrameIdx, mUnder, mOver;
    bit mIdle, mWait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNum, obs, expv);
    endtask

    task automatic modelFlush(input bit clearCounters);
        mQ.delete();
        mWr = 0; mRd = 0; mPos = -1; mLine = 0; mPorch = 0; mFrameIdx = 0;
        mIdle = 1'b1; mWait = 1'b0;
        if (clearCounters) begin
            mUnder = 0;
            mOver  = 0;
        end
    endtask

    function automatic logic [EXP_W-1:0] packExp();
        logic v, u, ls, fs, wb, rb, bl;
        logic [AW-1:0] a;
        logic [CW-1:0] un, ov;
        v  = (mPos >= 0) && (mPos < W);
        a  = v ? AW'(mPos) : '0;
        u  = (mPos >= 0) && (mFrameIdx < U);
        ls = (mPos == 0);
        fs = (mPos == 0) && (mLine == 0);
        wb = mWr[0];
        rb = mRd[0];
        bl = (mQ.size() == 2);
        un = CW'(mUnder);
        ov = CW'(mOver);
        return {v, u, ls, fs, a, wb, rb, bl, un, ov};
    endfunction

    task automatic modelStep(input logic en, input logic wd);
        int preSize;
        if (!en) begin
            modelFlush(1'b0);
            return;
        end
        preSize = mQ.size();
        if (mIdle) begin
            mIdle = 1'b0;
            mWait = 1'b1;
        end else if (mWait) begin
            if (preSize > 0) begin
                mWait = 1'b0;
                mPos  = 0;
            end
        end else if (mPos >= 0) begin
            mFrameIdx++;
            if (mPos < W + B - 1) begin
                mPos++;
            end else begin
                void'(mQ.pop_front());
                mRd++;
                if (mLine == L - 1) begin
                    mLine  = 0;
                    mPos   = -1;
                    mPorch = P;
                end else begin
                    mLine++;
                    if (preSize == 2) begin
                        mPos = 0;
                    end else begin
                        mPos  = -1;
                        mWait = 1'b1;
                        if (mUnder < CNT_MAX) mUnder++;
                    end
                end
            end
        end else if (mPorch > 0) begin
            mPorch--;
            if (mPorch == 0) begin
                mWait     = 1'b1;
                mFrameIdx = 0;
            end
        end
        if (wd) begin
            if (preSize == 2) begin
                if (mOver < CNT_MAX) mOver++;
            end else begin
                mQ.push_back(mWr);
                mWr++;
            end
        end
    endtask

    task automatic checkOutputs();
        logic [EXP_W-1:0] e;
        logic v, u, ls, fs, wb, rb, bl;
        logic [AW-1:0] a;
        logic [CW-1:0] un, ov;
        if (exp_q.size() == 0) begin
            checkCount++;
            $error("FAIL exp_q_empty cycle=%0d observed=0 expected=1", cycleNum);
            return;
        end
        e = exp_q.pop_front();
        {v, u, ls, fs, a, wb, rb, bl, un, ov} = e;
        chk("valid",      32'(bus.o_valid),         32'(v));
        chk("rdAddr",     32'(bus.o_rdAddr),        32'(a));
        chk("update",     32'(bus.o_update),        32'(u));
        chk("lineStart",  32'(bus.o_lineStart),     32'(ls));
        chk("frameStart", 32'(bus.o_frameStart),    32'(fs));
        chk("wrBuffer",   32'(bus.o_wrBuffer),      32'(wb));
        chk("rdBuffer",   32'(bus.o_rdBuffer),      32'(rb));
        chk("wrBlocked",  32'(bus.o_wrBlocked),     32'(bl));
        chk("underrun",   32'(bus.o_underrunCount), 32'(un));
        chk("overrun",    32'(bus.o_overrunCount),  32'(ov));
    endtask

    // Driver: apply inputs after a falling edge, step model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input logic en, input logic wd);
        bus.i_enable     = en;
        bus.i_wrLineDone = wd;
        @(posedge clock);
        modelStep(en, wd);
        exp_q.push_back(packExp());
        @(negedge clock);
        cycleNum++;
        checkOutputs();
    endtask

    task automatic stepAhead();
        step(1'b1, (mQ.size() < 2) && ($urandom_range(0, 3) != 0));
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_valid"},     32'(bus.o_valid),         32'd0);
        chk({tag, "_rdAddr"},    32'(bus.o_rdAddr),        32'd0);
        chk({tag, "_update"},    32'(bus.o_update),        32'd0);
        chk({tag, "_lineStart"}, 32'(bus.o_lineStart),     32'd0);
        chk({tag, "_frameStrt"}, 32'(bus.o_frameStart),    32'd0);
        chk({tag, "_wrBuffer"},  32'(bus.o_wrBuffer),      32'd0);
        chk({tag, "_rdBuffer"},  32'(bus.o_rdBuffer),      32'd0);
        chk({tag, "_wrBlocked"}, 32'(bus.o_wrBlocked),     32'd0);
        chk({tag, "_underrun"},  32'(bus.o_underrunCount), 32'd0);
        chk({tag, "_overrun"},   32'(bus.o_overrunCount),  32'd0);
    endtask

    initial begin
        nReset = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_wrLineDone = 1'b0;
        modelFlush(1'b1);
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        nReset = 1'b1;

        // Single line: one write, 40 valid words, 4 blanks, buffer swap.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

        // Writer kept ahead for two full frames including porch.
        for (int i = 0; i < 2 * (L * (W + B) + P) + 40; i++) stepAhead();

        // Drop enable mid-line at word 17, then restart from line 0.
        for (int i = 0; i < 200 && mPos != 17; i++) stepAhead();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) stepAhead();

        // Overruns: three back-to-back writes, then a write on the release cycle.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 100 && mPos != W + B - 1; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

        // Line 2 arrives ten cycles after the reader started waiting for it.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 200 && !(mWait && mLine == 2); i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

        // Forced stalls until the underrun counter saturates, then more stalls.
        for (int i = 0; i < 4000 && mUnder < CNT_MAX; i++) step(1'b1, mWait && mQ.size() == 0);
        for (int i = 0; i < 150; i++) step(1'b1, mWait && mQ.size() == 0);
        chk("underrun_saturated", 32'(bus.o_underrunCount), 32'(CNT_MAX));

        // Random writer rate with occasional enable drops.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, (i < 750) ? 19 : 59) == 0);
        end

        // Asynchronous reset mid-line clears everything, counters included.
        step(1'b1, 1'b0);
        for (int i = 0; i < 400 && mPos != 20; i++) stepAhead();
        #2 nReset = 1'b0;
        #1 checkAllZero("async");
        modelFlush(1'b1);
        @(negedge clock);
        nReset = 1'b1;
        for (int i = 0; i < 60; i++) stepAhead();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
